// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the serial pattern generator.
//   - FSM state encodings (IDLE, SEND, GAP, DONE)
//   - PRBS-7 filler polynomial (x^7 + x^6 + 1) and seed
//   - width helpers for the pattern-length and bit-index fields
package seq_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Tap mask: feedback is the XOR of bits 6 and 5 (x^7 and x^6 terms).
  localparam logic [6:0] PRBS_POLY = 7'h60;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // Width of pat_len: must hold the value PAT_W itself.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  // Width of a bit index 0..PAT_W-1 (at least one bit).
  function automatic int idx_w(input int pat_w);
    return (pat_w > 1) ? $clog2(pat_w) : 1;
  endfunction

endpackage

// File: rtl/seq_gen_lfsr.sv
// seq_gen_lfsr: PRBS-7 generator (x^7 + x^6 + 1) with advance enable.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, loads PRBS_SEED
//   en   - advance the sequence by one step this cycle
//   prbs - current sequence bit (MSB of the shift register)
module seq_gen_lfsr
  import seq_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic prbs
);

  logic [6:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= PRBS_SEED;
    end else if (en) begin
      lfsr <= {lfsr[5:0], ^(lfsr & PRBS_POLY)};
    end
  end

  assign prbs = lfsr[6];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern generator.
// Latches a 1..PAT_W bit pattern and shifts it out MSB-first on o, repeating
// it reps times (0 = until abort) with gap idle cycles between repetitions.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - run request, honoured only in IDLE with a legal pat_len
//   pattern, pat_len  - pattern bits and length; pattern[pat_len-1] goes first
//   reps, gap         - repetition count (0 = continuous), inter-repetition gap
//   abort             - end any run immediately, no done pulse
//   o, o_valid        - serial bit and its qualifier
//   frame             - first bit of each repetition
//   busy, done        - run in progress; one-cycle end-of-run pulse
// Build option: define SEQ_GEN_PRBS_FILL_EN to fill gap cycles with valid
// PRBS-7 bits instead of o=0/o_valid=0.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [len_w(PAT_W)-1:0]  pat_len,
  input  logic [REP_W-1:0]         reps,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     abort,
  output logic                     o,
  output logic                     o_valid,
  output logic                     frame,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = len_w(PAT_W);
  localparam int IW = idx_w(PAT_W);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LW-1:0]    len_q, len_n;
  logic [REP_W-1:0] reps_q, reps_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n, rep_inc;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             o_n, o_valid_n, frame_n;
  logic             latch;
  logic             fill_bit;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    latch     = 1'b0;
    rep_inc   = rep_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (start && (pat_len != '0) && (pat_len <= LW'(PAT_W))) begin
          latch     = 1'b1;
          state_n   = ST_SEND;
          bit_idx_n = IW'(pat_len - 1'b1);
          rep_cnt_n = '0;
        end
      end
      ST_SEND: begin
        if (bit_idx == '0) begin
          rep_cnt_n = rep_inc;
          if ((reps_q != '0) && (rep_inc == reps_q)) begin
            state_n = ST_DONE;
          end else if (gap_q != '0) begin
            state_n   = ST_GAP;
            gap_cnt_n = gap_q;
          end else begin
            bit_idx_n = IW'(len_q - 1'b1);
          end
        end else begin
          bit_idx_n = bit_idx - 1'b1;
        end
      end
      ST_GAP: begin
        // gap_cnt counts the gap cycles still to be shown, including this one.
        if (gap_cnt == GAP_W'(1)) begin
          state_n   = ST_SEND;
          bit_idx_n = IW'(len_q - 1'b1);
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;  // ST_DONE
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
    end
  end

  // Run parameters as seen by the next cycle: fresh inputs on the accepting
  // edge, otherwise the latched copy.
  assign pat_n  = latch ? pattern : pat_q;
  assign len_n  = latch ? pat_len : len_q;
  assign reps_n = latch ? reps    : reps_q;
  assign gap_n  = latch ? gap     : gap_q;

`ifdef SEQ_GEN_PRBS_FILL_EN
  // Advance once per gap cycle produced, so each filler bit is fresh.
  seq_gen_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (state_n == ST_GAP),
    .prbs (fill_bit)
  );
`else
  assign fill_bit = 1'b0;
`endif

  // Outputs are decoded from the next state so they appear registered and
  // aligned with the state they describe.
  always_comb begin
    o_n       = 1'b0;
    o_valid_n = 1'b0;
    frame_n   = 1'b0;
    case (state_n)
      ST_SEND: begin
        o_n       = pat_n[bit_idx_n];
        o_valid_n = 1'b1;
        frame_n   = (bit_idx_n == IW'(len_n - 1'b1));
      end
      ST_GAP: begin
`ifdef SEQ_GEN_PRBS_FILL_EN
        o_n       = fill_bit;
        o_valid_n = 1'b1;
`else
        o_n       = fill_bit;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      frame   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      reps_q  <= reps_n;
      gap_q   <= gap_n;
      bit_idx <= bit_idx_n;
      rep_cnt <= rep_cnt_n;
      gap_cnt <= gap_cnt_n;
      o       <= o_n;
      o_valid <= o_valid_n;
      frame   <= frame_n;
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed self-checking bench for seq_pattern_gen.
// Each cycle's outputs are compared as the vector {o, o_valid, frame, busy, done}.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic [7:0] reps = '0;
  logic [3:0] gap = '0;
  logic       o, o_valid, frame, busy, done;

  int vectors = 0;
  int miscompares = 0;

  // Golden PRBS-7 (x^7 + x^6 + 1), seeded 7'h7F, output bit = MSB.
  logic [6:0] prbs_model = 7'h7F;

  localparam logic [4:0] IDLE_V = 5'b00000;
  localparam logic [4:0] DONE_V = 5'b00011;

  wire [4:0] obs = {o, o_valid, frame, busy, done};

  seq_pattern_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .pat_len (pat_len),
    .reps    (reps),
    .gap     (gap),
    .abort   (abort),
    .o       (o),
    .o_valid (o_valid),
    .frame   (frame),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] data_v(input logic b, input logic f);
    return {b, 1'b1, f, 1'b1, 1'b0};
  endfunction

  task automatic next_gap_v(output logic [4:0] e);
`ifdef SEQ_GEN_PRBS_FILL_EN
    e = {prbs_model[6], 1'b1, 1'b0, 1'b1, 1'b0};
    prbs_model = {prbs_model[5:0], prbs_model[6] ^ prbs_model[5]};
`else
    e = 5'b00010;
`endif
  endtask

  task automatic start_run(input logic [7:0] p, input int l, input int r, input int g);
    pattern = p;
    pat_len = 4'(l);
    reps    = 8'(r);
    gap     = 4'(g);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    pattern = 8'hFF;
    pat_len = 4'd8;
    step();
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset_hold: got %b expected %b", obs, IDLE_V);
    end
    start = 1'b0;
    rst   = 1'b0;
    prbs_model = 7'h7F;
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bits;
    logic [4:0] e;
    bits = 4'b1101;
    start_run(8'b0000_1101, 4, 2, 0);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8)       e = data_v(bits[3 - ((c - 1) % 4)], ((c - 1) % 4) == 0);
      else if (c == 9)  e = DONE_V;
      else              e = IDLE_V;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, e);
      end
      if (c < 10) step();
    end
  endtask

  task automatic test_gap(input int g);
    logic [3:0] bits;
    logic [4:0] e;
    int last;
    bits = 4'b1101;
    last = 10 + g;
    start_run(8'b0000_1101, 4, 2, g);
    for (int c = 1; c <= last; c++) begin
      if (c <= 4)            e = data_v(bits[4 - c], c == 1);
      else if (c <= 4 + g)   next_gap_v(e);
      else if (c <= 8 + g)   e = data_v(bits[8 + g - c], c == 5 + g);
      else if (c == 9 + g)   e = DONE_V;
      else                   e = IDLE_V;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL gap%0d cycle %0d: got %b expected %b", g, c, obs, e);
      end
      if (c < last) step();
    end
  endtask

  task automatic test_continuous_abort();
    logic [2:0] bits;
    logic [4:0] e;
    bits = 3'b101;
    start_run(8'b0000_0101, 3, 0, 0);
    for (int c = 1; c <= 30; c++) begin
      e = data_v(bits[2 - ((c - 1) % 3)], ((c - 1) % 3) == 0);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL continuous cycle %0d: got %b expected %b", c, obs, e);
      end
      if (c == 30) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    for (int c = 31; c <= 34; c++) begin
      vectors++;
      if (obs !== IDLE_V) begin
        miscompares++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, obs, IDLE_V);
      end
      step();
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0] bits;
    logic [4:0] e;
    bits = 4'b1101;
    start_run(8'b0000_1101, 4, 1, 0);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4)      e = data_v(bits[4 - c], c == 1);
      else if (c == 5) e = DONE_V;
      else             e = IDLE_V;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL start_while_busy cycle %0d: got %b expected %b", c, obs, e);
      end
      if (c == 2) begin
        pattern = 8'hFF;
        pat_len = 4'd8;
        reps    = 8'd5;
        gap     = 4'd2;
        start   = 1'b1;
      end
      if (c == 3) start = 1'b0;
      if (c < 6) step();
    end
    // Illegal lengths in IDLE must not start a run.
    pat_len = 4'd0;
    start   = 1'b1;
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL len0_start: got %b expected %b", obs, IDLE_V);
    end
    pat_len = 4'd9;
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL len9_start: got %b expected %b", obs, IDLE_V);
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_rst_mid();
    logic [7:0] bits;
    logic [4:0] e;
    start_run(8'b0000_1101, 4, 3, 0);
    vectors++;
    if (obs !== data_v(1'b1, 1'b1)) begin
      miscompares++;
      $display("FAIL rst_mid bit1: got %b expected %b", obs, data_v(1'b1, 1'b1));
    end
    step();
    vectors++;
    if (obs !== data_v(1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL rst_mid bit2: got %b expected %b", obs, data_v(1'b1, 1'b0));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    prbs_model = 7'h7F;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL rst_mid outputs: got %b expected %b", obs, IDLE_V);
    end
    bits = 8'b1011_0010;
    start_run(bits, 8, 1, 0);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8)      e = data_v(bits[8 - c], c == 1);
      else if (c == 9) e = DONE_V;
      else             e = IDLE_V;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL after_rst cycle %0d: got %b expected %b", c, obs, e);
      end
      if (c < 10) step();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap(3);
    test_gap(7);
    test_continuous_abort();
    test_start_ignored();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
